// File: rtl/uv_pkg.sv
// Shared types and timing constants for the ultrasonic range classifier.
// Holds echo class codes, timer FSM states and 50 MHz timing constants.
package uv_pkg;

   typedef enum logic [1:0] {
      CLS_NONE  = 2'd0,
      CLS_BLOCK = 2'd1,
      CLS_FAULT = 2'd2
   } cls_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_GAP
   } state_t;

   localparam int unsigned T_10US = 500;
   localparam int unsigned T_25MS = 1250000;
   localparam int unsigned T_60MS = 3000000;

   // Window edges are excluded; a timeout never classifies.
   function automatic cls_t classify(
      input logic [31:0] w,
      input logic        tmo,
      input int unsigned flo,
      input int unsigned fhi,
      input int unsigned blo,
      input int unsigned bhi
   );
      cls_t c;
      c = CLS_NONE;
      if (!tmo && w > flo && w < fhi)
         c = CLS_FAULT;
      else if (!tmo && w > blo && w < bhi)
         c = CLS_BLOCK;
      return c;
   endfunction

endpackage

// File: rtl/uv_echo_timer.sv
// Ultrasonic ping sequencer: trigger, echo rise wait, width measure, gap.
// Ports: clk_50M/reset, enable, UV_echo in; UV_trig, width, valid, tmo out.
module uv_echo_timer
   import uv_pkg::*;
#(
   parameter int unsigned TRIG_CYC    = T_10US,
   parameter int unsigned GAP_CYC     = T_60MS,
   parameter int unsigned TIMEOUT_CYC = T_25MS,
   parameter int unsigned ECHO_W      = 21
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic              enable,
   input  logic              UV_echo,
   output logic              UV_trig,
   output logic [ECHO_W-1:0] width,
   output logic              valid,
   output logic              tmo
);

   logic [1:0]  sync;
   logic        echo_s;
   state_t      state;
   state_t      state_n;
   logic [31:0] cnt;
   logic [31:0] cnt_n;
   logic        rec;
   logic        rec_tmo;

   assign echo_s = sync[1];

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         sync  <= '0;
         state <= S_IDLE;
         cnt   <= '0;
         width <= '0;
         valid <= 1'b0;
         tmo   <= 1'b0;
      end else begin
         sync  <= {sync[0], UV_echo};
         state <= state_n;
         cnt   <= cnt_n;
         valid <= rec;
         tmo   <= rec & rec_tmo;
         if (rec)
            width <= rec_tmo ? '0 : cnt[ECHO_W-1:0];
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rec     = 1'b0;
      rec_tmo = 1'b0;
      UV_trig = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (enable) begin
               state_n = S_TRIG;
               cnt_n   = '0;
            end
         end
         S_TRIG: begin
            UV_trig = 1'b1;
            if (cnt == TRIG_CYC - 1) begin
               state_n = S_WAIT_RISE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_WAIT_RISE: begin
            // The rise cycle itself is the first high cycle.
            if (echo_s) begin
               state_n = S_MEASURE;
               cnt_n   = 32'd1;
            end else if (cnt == TIMEOUT_CYC - 1) begin
               rec     = 1'b1;
               rec_tmo = 1'b1;
               state_n = S_GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_MEASURE: begin
            if (!echo_s) begin
               rec     = 1'b1;
               state_n = S_GAP;
               cnt_n   = '0;
            end else if (cnt == TIMEOUT_CYC) begin
               rec     = 1'b1;
               rec_tmo = 1'b1;
               state_n = S_GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_GAP: begin
            if (cnt == GAP_CYC - 1) begin
               state_n = enable ? S_TRIG : S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: rtl/uv_range_classifier.sv
// Classifies echo widths into fault/block windows with streak confirmation.
// Ports: sensor pins, sample/timeout status, pickup/drop events, EM drive.
module uv_range_classifier
   import uv_pkg::*;
#(
   parameter int unsigned TRIG_CYC    = T_10US,
   parameter int unsigned GAP_CYC     = T_60MS,
   parameter int unsigned TIMEOUT_CYC = T_25MS,
   parameter int unsigned ECHO_W      = 21,
   parameter int unsigned FAULT_LO    = 17000,
   parameter int unsigned FAULT_HI    = 19000,
   parameter int unsigned BLOCK_LO    = 8000,
   parameter int unsigned BLOCK_HI    = 10000,
   parameter int unsigned CONFIRM     = 2
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic              enable,
   input  logic              UV_echo,
   output logic              UV_trig,
   output logic [ECHO_W-1:0] echo_width,
   output logic              sample_valid,
   output logic              timeout_err,
   output logic              fault_detect,
   output logic              object_drop,
   output logic              block_picked,
   output logic              EM_a1,
   output logic              EM_b1
);

   localparam logic [3:0] CONF = 4'(CONFIRM);

   cls_t       cls;
   cls_t       last_cls;
   logic [3:0] streak;
   logic [3:0] streak_n;
   logic       fire;

   uv_echo_timer #(
      .TRIG_CYC    (TRIG_CYC),
      .GAP_CYC     (GAP_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .ECHO_W      (ECHO_W)
   ) u_timer (
      .clk_50M (clk_50M),
      .reset   (reset),
      .enable  (enable),
      .UV_echo (UV_echo),
      .UV_trig (UV_trig),
      .width   (echo_width),
      .valid   (sample_valid),
      .tmo     (timeout_err)
   );

   assign EM_b1 = 1'b0;

   always_comb begin
      cls = classify(32'(echo_width), timeout_err,
                     FAULT_LO, FAULT_HI, BLOCK_LO, BLOCK_HI);
      streak_n = 4'd1;
      if (cls == last_cls)
         streak_n = (streak >= CONF) ? CONF : streak + 4'd1;
      // Fire only on the transition into a full streak.
      fire = sample_valid && (streak_n == CONF) &&
             !((cls == last_cls) && (streak == CONF));
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         last_cls     <= CLS_NONE;
         streak       <= '0;
         fault_detect <= 1'b0;
         object_drop  <= 1'b0;
         block_picked <= 1'b0;
         EM_a1        <= 1'b0;
      end else begin
         fault_detect <= 1'b0;
         object_drop  <= 1'b0;
         EM_a1        <= block_picked;
         if (sample_valid) begin
            last_cls <= cls;
            streak   <= streak_n;
         end
         if (fire) begin
            if (cls == CLS_FAULT) begin
               if (block_picked) begin
                  object_drop  <= 1'b1;
                  block_picked <= 1'b0;
               end else begin
                  fault_detect <= 1'b1;
               end
            end else if (cls == CLS_BLOCK) begin
               block_picked <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uv_range_classifier.sv
// Bench for uv_range_classifier with scaled timing and a sample-history model.
// Drives pings directed then random; checks widths, timing and actions.
module tb_uv_range_classifier;

   localparam int TRIG = 10;
   localparam int GAP  = 20;
   localparam int TMO  = 400;
   localparam int EW   = 10;
   localparam int FLO  = 170;
   localparam int FHI  = 190;
   localparam int BLO  = 80;
   localparam int BHI  = 100;
   localparam int CONF = 2;

   logic          clk_50M = 1'b0;
   logic          reset   = 1'b1;
   logic          enable  = 1'b0;
   logic          UV_echo = 1'b0;
   logic          UV_trig;
   logic [EW-1:0] echo_width;
   logic          sample_valid;
   logic          timeout_err;
   logic          fault_detect;
   logic          object_drop;
   logic          block_picked;
   logic          EM_a1;
   logic          EM_b1;

   int checks   = 0;
   int failures = 0;
   int hist[$];
   bit held     = 1'b0;
   int exp_fd   = 0;
   int exp_od   = 0;
   int mon_fd   = 0;
   int mon_od   = 0;
   int bnd[4]   = '{FLO, FHI, BLO, BHI};

   uv_range_classifier #(
      .TRIG_CYC    (TRIG),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (TMO),
      .ECHO_W      (EW),
      .FAULT_LO    (FLO),
      .FAULT_HI    (FHI),
      .BLOCK_LO    (BLO),
      .BLOCK_HI    (BHI),
      .CONFIRM     (CONF)
   ) dut (
      .clk_50M      (clk_50M),
      .reset        (reset),
      .enable       (enable),
      .UV_echo      (UV_echo),
      .UV_trig      (UV_trig),
      .echo_width   (echo_width),
      .sample_valid (sample_valid),
      .timeout_err  (timeout_err),
      .fault_detect (fault_detect),
      .object_drop  (object_drop),
      .block_picked (block_picked),
      .EM_a1        (EM_a1),
      .EM_b1        (EM_b1)
   );

   always #10 clk_50M = ~clk_50M;

   always @(negedge clk_50M) begin
      if (!reset) begin
         if (fault_detect) mon_fd++;
         if (object_drop)  mon_od++;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_cls(input int w, input bit t);
      if (t) return 0;
      if (w > FLO && w < FHI) return 2;
      if (w > BLO && w < BHI) return 1;
      return 0;
   endfunction

   // Length of the run of identical classes ending at the newest sample.
   function automatic int run_len();
      int n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != hist[hist.size()-1]) break;
         n++;
      end
      return n;
   endfunction

   task automatic wait_trig(output int hw);
      int n = 0;
      hw = 0;
      while (!UV_trig && n < 100) begin
         @(negedge clk_50M);
         n++;
      end
      while (UV_trig && n < 100) begin
         @(negedge clk_50M);
         n++;
         hw++;
      end
   endtask

   // kind 0: echo of w cycles, 1: no rise, 2: echo stuck high
   task automatic ping(input int kind, input int w);
      int hw;
      int n;
      int d;
      int c;
      bit t;
      int expw;
      bit efd;
      bit eod;
      wait_trig(hw);
      chk("trig_width", hw, TRIG);
      n = 0;
      if (kind == 0) begin
         d = $urandom_range(0, 5);
         repeat (d) @(negedge clk_50M);
         UV_echo = 1'b1;
         repeat (w) @(negedge clk_50M);
         UV_echo = 1'b0;
         n = d + w;
      end else if (kind == 2) begin
         UV_echo = 1'b1;
      end
      while (!sample_valid && n < TMO + 100) begin
         @(negedge clk_50M);
         n++;
      end
      if (!sample_valid) begin
         chk("valid_seen", 0, 1);
         UV_echo = 1'b0;
         return;
      end
      if (kind == 1) chk("tmo_latency", n, TMO);
      t    = (kind != 0);
      expw = t ? 0 : w;
      chk("echo_width", 32'(echo_width), expw);
      chk("timeout_err", 32'(timeout_err), 32'(t));
      chk("fd_at_valid", 32'(fault_detect), 0);
      chk("od_at_valid", 32'(object_drop), 0);
      c = ref_cls(expw, t);
      hist.push_back(c);
      efd = 1'b0;
      eod = 1'b0;
      if (run_len() == CONF) begin
         if (c == 2) begin
            if (held) begin
               eod  = 1'b1;
               held = 1'b0;
            end else begin
               efd = 1'b1;
            end
         end else if (c == 1) begin
            held = 1'b1;
         end
      end
      exp_fd += int'(efd);
      exp_od += int'(eod);
      UV_echo = 1'b0;
      @(negedge clk_50M);
      chk("valid_pulse", 32'(sample_valid), 0);
      chk("fault_detect", 32'(fault_detect), 32'(efd));
      chk("object_drop", 32'(object_drop), 32'(eod));
      chk("block_picked", 32'(block_picked), 32'(held));
      @(negedge clk_50M);
      chk("EM_a1", 32'(EM_a1), 32'(held));
      chk("EM_b1", 32'(EM_b1), 0);
   endtask

   task automatic reps(input int w, input int k);
      for (int i = 0; i < k; i++) ping(0, w);
   endtask

   initial begin
      int hw;
      int r;
      int w;
      int k;
      #55;
      chk("rst_trig", 32'(UV_trig), 0);
      chk("rst_width", 32'(echo_width), 0);
      chk("rst_valid", 32'(sample_valid), 0);
      chk("rst_block", 32'(block_picked), 0);
      chk("rst_em", 32'(EM_a1), 0);
      @(negedge clk_50M);
      reset  = 1'b0;
      enable = 1'b1;

      reps(180, 3);
      reps(90, 2);
      reps(180, 2);
      ping(1, 0);
      ping(2, 0);
      reps(FLO, CONF);
      reps(FHI, CONF);
      reps(BLO, CONF);
      reps(BHI, CONF);
      reps(FLO + 1, CONF);
      reps(BHI - 1, CONF);
      for (int i = 0; i < 3; i++) begin
         ping(0, 180);
         ping(0, 90);
      end

      reps(90, 2);
      wait_trig(hw);
      UV_echo = 1'b1;
      repeat (30) @(negedge clk_50M);
      #3 reset = 1'b1;
      #1;
      chk("arst_trig", 32'(UV_trig), 0);
      chk("arst_width", 32'(echo_width), 0);
      chk("arst_valid", 32'(sample_valid), 0);
      chk("arst_tmo", 32'(timeout_err), 0);
      chk("arst_fd", 32'(fault_detect), 0);
      chk("arst_od", 32'(object_drop), 0);
      chk("arst_block", 32'(block_picked), 0);
      chk("arst_em_a", 32'(EM_a1), 0);
      chk("arst_em_b", 32'(EM_b1), 0);
      UV_echo = 1'b0;
      hist.delete();
      held = 1'b0;
      @(negedge clk_50M);
      reset = 1'b0;
      ping(0, 150);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         k = $urandom_range(1, 3);
         if (r == 0) begin
            ping(1, 0);
         end else begin
            if (r <= 3)      w = $urandom_range(FLO + 1, FHI - 1);
            else if (r <= 6) w = $urandom_range(BLO + 1, BHI - 1);
            else if (r == 7) w = bnd[$urandom_range(0, 3)];
            else             w = $urandom_range(1, TMO - 1);
            reps(w, k);
         end
      end

      repeat (3) @(negedge clk_50M);
      chk("fd_total", mon_fd, exp_fd);
      chk("od_total", mon_od, exp_od);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
